// File: rtl/braille_uart_tx_if.sv
// Decoder-side inputs and UART-side status outputs of braille_uart_tx.
// The testbench (or upstream glue) is the master; the transmitter is the slave.
interface braille_uart_tx_if;
  logic [7:0] Y;
  logic       INV;
  logic       TX;
  logic       BSY;
  logic       OVF;
  logic [7:0] ERR;

  modport master (
    output Y,
    output INV,
    input  TX,
    input  BSY,
    input  OVF,
    input  ERR
  );

  modport slave (
    input  Y,
    input  INV,
    output TX,
    output BSY,
    output OVF,
    output ERR
  );
endinterface

// File: rtl/braille_uart_tx.sv
// Captures decoded braille characters once per cell, buffers valid ones in a FIFO
// and ships them out as 8N1 UART frames; invalid cells are counted in ERR.
module braille_uart_tx #(
  parameter int unsigned CELL_BITS    = 6,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              CLK,
  input  logic              R,
  braille_uart_tx_if.slave  bus
);

  localparam int unsigned BC_W      = (CELL_BITS > 1) ? $clog2(CELL_BITS) : 1;
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W     = 3;
  localparam int unsigned ERR_W     = 8;

  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(CELL_BITS - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);
  localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(255);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Cell framing and capture state
  logic [BC_W-1:0]   r_bc;
  logic              r_cell_done;
  logic [ERR_W-1:0]  r_err;
  logic              r_ovf;

  // FIFO state
  logic [7:0]        r_fifo [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Transmitter state
  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_bsy;

  // Combinational next values
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push_acc;
  logic              w_drop;
  logic              w_baud_last;
  logic [7:0]        w_head;
  logic [CNT_W-1:0]  w_count_nx;
  state_t            w_state_nx;
  logic [BAUD_W-1:0] w_baud_nx;
  logic [BIT_W-1:0]  w_bit_nx;
  logic [7:0]        w_shift_nx;
  logic              w_tx_nx;
  logic              w_bsy_nx;

  // Capture decision and FIFO bookkeeping; a pop in the same cycle frees a full slot.
  always_comb begin
    w_push     = r_cell_done & ~bus.INV;
    w_full     = (r_count == CNT_FULL);
    w_empty    = (r_count == '0);
    w_head     = r_fifo[r_rd_ptr];
    w_push_acc = w_push & (~w_full | w_pop);
    w_drop     = w_push & w_full & ~w_pop;
    unique case ({w_push_acc, w_pop})
      2'b10:   w_count_nx = r_count + CNT_W'(1);
      2'b01:   w_count_nx = r_count - CNT_W'(1);
      default: w_count_nx = r_count;
    endcase
  end

  // UART framing FSM: next state, shift/baud/bit counters and next line level.
  always_comb begin
    w_state_nx  = r_state;
    w_baud_nx   = r_baud + BAUD_W'(1);
    w_bit_nx    = r_bit_idx;
    w_shift_nx  = r_shift;
    w_tx_nx     = r_tx;
    w_pop       = 1'b0;
    w_baud_last = (r_baud == BAUD_LAST);

    unique case (r_state)
      S_IDLE: begin
        w_baud_nx = '0;
        w_tx_nx   = 1'b1;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = w_head;
          w_state_nx = S_START;
          w_tx_nx    = 1'b0;
        end
      end
      S_START: begin
        w_tx_nx = 1'b0;
        if (w_baud_last) begin
          w_baud_nx  = '0;
          w_bit_nx   = '0;
          w_state_nx = S_DATA;
          w_tx_nx    = r_shift[0];
        end
      end
      S_DATA: begin
        w_tx_nx = r_shift[0];
        if (w_baud_last) begin
          w_baud_nx = '0;
          if (r_bit_idx == BIT_LAST) begin
            w_state_nx = S_STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_nx   = r_bit_idx + BIT_W'(1);
            w_shift_nx = r_shift >> 1;
            w_tx_nx    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        w_tx_nx = 1'b1;
        if (w_baud_last) begin
          w_baud_nx = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = w_head;
            w_state_nx = S_START;
            w_tx_nx    = 1'b0;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_baud_nx  = '0;
        w_tx_nx    = 1'b1;
      end
    endcase

    w_bsy_nx = (w_state_nx != S_IDLE) || (w_count_nx != '0);
  end

  // Cell bit counter, capture flags and error/overflow status.
  always_ff @(posedge CLK) begin
    if (!R) begin
      r_bc        <= '0;
      r_cell_done <= 1'b0;
      r_err       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_bc        <= (r_bc == BC_LAST) ? '0 : r_bc + BC_W'(1);
      r_cell_done <= (r_bc == BC_LAST);
      if (r_cell_done && bus.INV && (r_err != ERR_MAX)) begin
        r_err <= r_err + ERR_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (!R) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nx;
    end
  end

  // FIFO storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (R && w_push_acc) begin
      r_fifo[r_wr_ptr] <= bus.Y;
    end
  end

  // Transmitter state register and registered outputs.
  always_ff @(posedge CLK) begin
    if (!R) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_bsy     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_baud    <= w_baud_nx;
      r_bit_idx <= w_bit_nx;
      r_shift   <= w_shift_nx;
      r_tx      <= w_tx_nx;
      r_bsy     <= w_bsy_nx;
    end
  end

  assign bus.TX  = r_tx;
  assign bus.BSY = r_bsy;
  assign bus.OVF = r_ovf;
  assign bus.ERR = r_err;

endmodule

// File: tb/tb_braille_uart_tx.sv
// Self-checking bench for braille_uart_tx: two instances (4 and 100 clocks per bit)
// share the stimulus; a behavioural UART receiver decodes each TX line.
module tb_braille_uart_tx;

  localparam int CPB_A  = 4;
  localparam int CPB_B  = 100;
  localparam int DEPTH  = 8;
  localparam int MAXRX  = 64;

  logic       clk;
  logic       r;
  logic [7:0] tb_y;
  logic       tb_inv;
  bit         mon_clr;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  braille_uart_tx_if if4 ();
  braille_uart_tx_if if100 ();

  assign if4.Y     = tb_y;
  assign if4.INV   = tb_inv;
  assign if100.Y   = tb_y;
  assign if100.INV = tb_inv;

  braille_uart_tx #(.CELL_BITS(6), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB_A)) u_dut4 (
    .CLK (clk),
    .R   (r),
    .bus (if4)
  );

  braille_uart_tx #(.CELL_BITS(6), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB_B)) u_dut100 (
    .CLK (clk),
    .R   (r),
    .bus (if100)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8N1 receivers: detect the falling start edge, sample mid-bit.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int CPB = (g == 0) ? CPB_A : CPB_B;
    wire w_line = (g == 0) ? if4.TX : if100.TX;
    logic [7:0] rx_b  [MAXRX];
    int         rx_st [MAXRX];
    int         rx_n = 0;
    int         ferr = 0;
    initial begin : p_rx
      bit         act;
      int         t;
      int         k;
      logic [7:0] sh;
      act = 1'b0;
      t   = 0;
      sh  = '0;
      forever begin
        @(negedge clk);
        if (mon_clr) begin
          act  = 1'b0;
          rx_n = 0;
          ferr = 0;
        end else if (!act) begin
          if (w_line === 1'b0) begin
            act = 1'b1;
            t   = 0;
            if (rx_n < MAXRX) rx_st[rx_n] = cyc;
          end
        end else begin
          t++;
          if (t == CPB / 2) begin
            if (w_line !== 1'b0) ferr++;
          end else if (t > CPB / 2 && ((t - CPB / 2) % CPB) == 0) begin
            k = (t - CPB / 2) / CPB;
            if (k <= 8) begin
              sh[k-1] = w_line;
            end else begin
              if (w_line !== 1'b1) ferr++;
              if (rx_n < MAXRX) rx_b[rx_n] = sh;
              rx_n++;
              act = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    r       = 1'b0;
    mon_clr = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    r       = 1'b1;
    mon_clr = 1'b0;
  endtask

  // Ideal line level c cycles after reset for a frame whose start bit begins at cycle s.
  function automatic logic exp_line(input int c, input int s, input int cpb, input logic [7:0] b);
    int idx;
    if (c < s) return 1'b1;
    idx = (c - s) / cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    r       = 1'b0;
    mon_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tb_y   = 8'($urandom);
      tb_inv = 1'($urandom);
      wait_edges(1);
      checks++; if (if4.TX !== 1'b1)    begin errors++; $display("FAIL reset_tx edge%0d got %b want 1", i, if4.TX); end
      checks++; if (if4.BSY !== 1'b0)   begin errors++; $display("FAIL reset_bsy edge%0d got %b want 0", i, if4.BSY); end
      checks++; if (if4.OVF !== 1'b0)   begin errors++; $display("FAIL reset_ovf edge%0d got %b want 0", i, if4.OVF); end
      checks++; if (if4.ERR !== 8'h00)  begin errors++; $display("FAIL reset_err edge%0d got %0d want 0", i, if4.ERR); end
      checks++; if (if100.TX !== 1'b1)  begin errors++; $display("FAIL reset_tx100 edge%0d got %b want 1", i, if100.TX); end
    end
  endtask

  task automatic test_single_char();
    logic exp;
    do_reset(1);
    wait_edges(6);
    tb_y   = 8'h39;
    tb_inv = 1'b0;
    for (int c = 7; c <= 49; c++) begin
      wait_edges(1);
      if (c == 7) begin
        tb_inv = 1'b1;
        tb_y   = 8'($urandom);
      end
      exp = exp_line(c, 8, CPB_A, 8'h39);
      checks++; if (if4.TX !== exp) begin errors++; $display("FAIL single_tx cycle%0d got %b want %b", c, if4.TX, exp); end
      if (c >= 8) begin
        exp = (c <= 47);
        checks++; if (if4.BSY !== exp) begin errors++; $display("FAIL single_bsy cycle%0d got %b want %b", c, if4.BSY, exp); end
      end
    end
    checks++; if (if4.ERR !== 8'd7) begin errors++; $display("FAIL single_err got %0d want 7", if4.ERR); end
    checks++; if (g_mon[0].rx_n !== 1) begin errors++; $display("FAIL single_rxcount got %0d want 1", g_mon[0].rx_n); end
    checks++; if (g_mon[0].rx_b[0] !== 8'h39) begin errors++; $display("FAIL single_rxbyte got %h want 39", g_mon[0].rx_b[0]); end
  endtask

  task automatic test_invalid();
    int tx_bad = 0;
    int exp_err;
    do_reset(1);
    wait_edges(6);
    tb_inv = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tb_y = 8'($urandom);
      wait_edges(1);
      if (if4.TX !== 1'b1 || if4.BSY !== 1'b0) tx_bad++;
      exp_err = (i + 1 > 255) ? 255 : i + 1;
      if (i == 0 || i == 9 || i == 253 || i == 254 || i == 299) begin
        checks++; if (if4.ERR !== 8'(exp_err)) begin errors++; $display("FAIL invalid_err cell%0d got %0d want %0d", i + 1, if4.ERR, exp_err); end
      end
      for (int e = 0; e < 5; e++) begin
        wait_edges(1);
        if (if4.TX !== 1'b1 || if4.BSY !== 1'b0) tx_bad++;
      end
    end
    checks++; if (tx_bad !== 0) begin errors++; $display("FAIL invalid_idle got %0d non-idle cycles want 0", tx_bad); end
    checks++; if (if4.OVF !== 1'b0) begin errors++; $display("FAIL invalid_ovf got %b want 0", if4.OVF); end
  endtask

  task automatic test_back_to_back();
    int r0;
    int budget;
    do_reset(1);
    r0 = cyc;
    wait_edges(6);
    tb_inv = 1'b0;
    tb_y   = 8'h41;
    wait_edges(6);
    tb_y   = 8'h42;
    wait_edges(6);
    tb_inv = 1'b1;
    budget = 200;
    while (g_mon[0].rx_n < 2 && budget > 0) begin
      wait_edges(1);
      budget--;
    end
    checks++; if (g_mon[0].rx_n !== 2) begin errors++; $display("FAIL b2b_rxcount got %0d want 2", g_mon[0].rx_n); end
    checks++; if (g_mon[0].rx_b[0] !== 8'h41 || g_mon[0].rx_b[1] !== 8'h42)
      begin errors++; $display("FAIL b2b_bytes got %h %h want 41 42", g_mon[0].rx_b[0], g_mon[0].rx_b[1]); end
    checks++; if (g_mon[0].rx_st[0] - r0 !== 8) begin errors++; $display("FAIL b2b_first_start got %0d want 8", g_mon[0].rx_st[0] - r0); end
    checks++; if (g_mon[0].rx_st[1] - g_mon[0].rx_st[0] !== 10 * CPB_A)
      begin errors++; $display("FAIL b2b_gap got %0d want %0d", g_mon[0].rx_st[1] - g_mon[0].rx_st[0], 10 * CPB_A); end
    checks++; if (g_mon[0].ferr !== 0) begin errors++; $display("FAIL b2b_framing got %0d want 0", g_mon[0].ferr); end
  endtask

  // Random cells against a timing model: frames start one edge after capture or
  // 10 bit-times after the previous start, whichever is later.
  task automatic test_random();
    logic [7:0] exp_b [$];
    int         exp_s [$];
    int         err_e  = 0;
    bit         ovf_e  = 1'b0;
    int         last_s = -1000;
    int         r0, tk, pend, s, budget;
    logic [7:0] y;
    bit         inv;
    do_reset(1);
    r0 = cyc;
    wait_edges(6);
    for (int i = 0; i < 40; i++) begin
      y      = 8'($urandom);
      inv    = ($urandom_range(3) == 0);
      tb_y   = y;
      tb_inv = inv;
      wait_edges(6);
      tk = 7 + 6 * i;
      if (inv) begin
        if (err_e < 255) err_e++;
      end else begin
        pend = 0;
        foreach (exp_s[j]) if (exp_s[j] > tk) pend++;
        if (pend >= DEPTH) begin
          ovf_e = 1'b1;
        end else begin
          s = (tk + 1 > last_s + 10 * CPB_A) ? tk + 1 : last_s + 10 * CPB_A;
          exp_b.push_back(y);
          exp_s.push_back(s);
          last_s = s;
        end
      end
    end
    checks++; if (if4.ERR !== 8'(err_e)) begin errors++; $display("FAIL random_err got %0d want %0d", if4.ERR, err_e); end
    checks++; if (if4.OVF !== ovf_e) begin errors++; $display("FAIL random_ovf got %b want %b", if4.OVF, ovf_e); end
    tb_inv = 1'b1;
    budget = 3000;
    while (g_mon[0].rx_n < exp_b.size() && budget > 0) begin
      wait_edges(1);
      budget--;
    end
    wait_edges(50);
    checks++; if (g_mon[0].rx_n !== exp_b.size()) begin errors++; $display("FAIL random_rxcount got %0d want %0d", g_mon[0].rx_n, exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < g_mon[0].rx_n && i < MAXRX; i++) begin
      checks++; if (g_mon[0].rx_b[i] !== exp_b[i]) begin errors++; $display("FAIL random_byte%0d got %h want %h", i, g_mon[0].rx_b[i], exp_b[i]); end
      checks++; if (g_mon[0].rx_st[i] - r0 !== exp_s[i]) begin errors++; $display("FAIL random_start%0d got %0d want %0d", i, g_mon[0].rx_st[i] - r0, exp_s[i]); end
    end
    checks++; if (g_mon[0].ferr !== 0) begin errors++; $display("FAIL random_framing got %0d want 0", g_mon[0].ferr); end
    checks++; if (if4.BSY !== 1'b0) begin errors++; $display("FAIL random_bsy_drained got %b want 0", if4.BSY); end
  endtask

  task automatic test_overflow();
    logic [7:0] ys [11];
    logic       exp;
    int         budget;
    do_reset(1);
    wait_edges(6);
    tb_inv = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ys[i] = 8'($urandom);
      tb_y  = ys[i];
      wait_edges(1);
      exp = (i >= 9);
      checks++; if (if100.OVF !== exp) begin errors++; $display("FAIL ovf_flag capture%0d got %b want %b", i + 1, if100.OVF, exp); end
      wait_edges(5);
    end
    tb_inv = 1'b1;
    budget = 11000;
    while (g_mon[1].rx_n < 9 && budget > 0) begin
      wait_edges(1);
      budget--;
    end
    wait_edges(1200);
    checks++; if (g_mon[1].rx_n !== 9) begin errors++; $display("FAIL ovf_rxcount got %0d want 9", g_mon[1].rx_n); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (g_mon[1].rx_b[i] !== ys[i]) begin errors++; $display("FAIL ovf_byte%0d got %h want %h", i, g_mon[1].rx_b[i], ys[i]); end
    end
    checks++; if (g_mon[1].ferr !== 0) begin errors++; $display("FAIL ovf_framing got %0d want 0", g_mon[1].ferr); end
    checks++; if (if100.OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", if100.OVF); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] y;
    do_reset(1);
    wait_edges(6);
    y      = 8'($urandom) & 8'hF7;
    tb_y   = y;
    tb_inv = 1'b0;
    wait_edges(1);
    tb_inv = 1'b1;
    wait_edges(18);
    checks++; if (if4.TX !== 1'b0) begin errors++; $display("FAIL midrst_bit3 got %b want 0", if4.TX); end
    checks++; if (if4.ERR !== 8'd3) begin errors++; $display("FAIL midrst_err_before got %0d want 3", if4.ERR); end
    do_reset(1);
    checks++; if (if4.TX !== 1'b1)   begin errors++; $display("FAIL midrst_tx got %b want 1", if4.TX); end
    checks++; if (if4.BSY !== 1'b0)  begin errors++; $display("FAIL midrst_bsy got %b want 0", if4.BSY); end
    checks++; if (if4.ERR !== 8'h00) begin errors++; $display("FAIL midrst_err got %0d want 0", if4.ERR); end
    for (int e = 1; e <= 6; e++) begin
      wait_edges(1);
      checks++; if (if4.BSY !== 1'b0 || if4.ERR !== 8'h00)
        begin errors++; $display("FAIL midrst_quiet edge%0d got bsy=%b err=%0d want 0 0", e, if4.BSY, if4.ERR); end
    end
    wait_edges(1);
    checks++; if (if4.ERR !== 8'd1) begin errors++; $display("FAIL midrst_capture7 got %0d want 1", if4.ERR); end
    checks++; if (g_mon[0].rx_n !== 0) begin errors++; $display("FAIL midrst_rxcount got %0d want 0", g_mon[0].rx_n); end
  endtask

  initial begin
    r       = 1'b0;
    tb_y    = '0;
    tb_inv  = 1'b0;
    mon_clr = 1'b1;
    test_reset();
    test_single_char();
    test_invalid();
    test_back_to_back();
    test_random();
    test_overflow();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
